// File: rtl/asconp_round_ctrl_if.sv
// Port bundle for asconp_round_ctrl: start/result handshakes with the mode controller,
// the randomness handshake with the PRNG, and the masked-permutation datapath taps.
interface asconp_round_ctrl_if #(
    parameter int D     = 2,
    parameter int RND_W = 5 * 64 * ((D - 1) * D / 2)
);
    // A transfer happens on a rising edge where valid (start_i, out_valid_o, rnd_valid_i)
    // and ready (ready_o, out_ready_i, rnd_ready_o) are both high; valid never waits on ready.
    logic                 start_i;
    logic                 ready_o;
    logic [3:0]           nrounds_i;
    logic [5*D*64-1:0]    state_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [5*D*64-1:0]    state_o;
    logic                 rnd_valid_i;
    logic                 rnd_ready_o;
    logic [RND_W-1:0]     rnd_i;
    logic [3:0]           perm_round_cnt_o;
    logic [RND_W-1:0]     perm_rdi_o;
    logic [5*D*64-1:0]    perm_x_o;
    logic [5*D*64-1:0]    perm_x_i;

    modport slave (
        input  start_i, nrounds_i, state_i, out_ready_i, rnd_valid_i, rnd_i, perm_x_i,
        output ready_o, out_valid_o, state_o, rnd_ready_o, perm_round_cnt_o, perm_rdi_o, perm_x_o
    );

    modport master (
        output start_i, nrounds_i, state_i, out_ready_i, rnd_valid_i, rnd_i, perm_x_i,
        input  ready_o, out_valid_o, state_o, rnd_ready_o, perm_round_cnt_o, perm_rdi_o, perm_x_o
    );
endinterface

// File: rtl/asconp_round_ctrl.sv
// Round sequencer for the D-share masked Ascon permutation (RND -> CALC -> UPD per round).
// Optional macro ASCONP_CTRL_ZEROIZE_EN clears state and randomness registers on result hand-off.
module asconp_round_ctrl #(
    parameter int D        = 2,
    parameter int RDI_BITS = (D - 1) * D / 2,
    parameter int RND_W    = 5 * 64 * RDI_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    asconp_round_ctrl_if.slave   bus,
    output logic [2:0]           dbg_state
);
    localparam int SW = 5 * D * 64;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RND  = 3'd1,
        CALC = 3'd2,
        UPD  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state_q;
    logic [SW-1:0]    st_q;
    logic [RND_W-1:0] rdi_q;
    logic [3:0]       cnt_q;
    logic             ready_q;
    logic             out_valid_q;
    logic [3:0]       eff_rounds;

    // Requests beyond a full p^12 are clamped rather than rejected.
    assign eff_rounds = (bus.nrounds_i > 4'd12) ? 4'd12 : bus.nrounds_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            st_q        <= '0;
            rdi_q       <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        st_q    <= bus.state_i;
                        cnt_q   <= eff_rounds;
                        ready_q <= 1'b0;
                        if (eff_rounds == 4'd0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= RND;
                        end
                    end
                end
                RND: begin
                    if (bus.rnd_valid_i) begin
                        rdi_q   <= bus.rnd_i;
                        state_q <= CALC;
                    end
                end
                // st_q and rdi_q must stay put here: the DOM-AND stage inside the
                // permutation captures its cross-share products during this cycle.
                CALC: begin
                    state_q <= UPD;
                end
                UPD: begin
                    st_q <= bus.perm_x_i;
                    if (cnt_q == 4'd1) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q - 4'd1;
                        state_q <= RND;
                    end
                end
                DONE: begin
                    if (bus.out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
`ifdef ASCONP_CTRL_ZEROIZE_EN
                        st_q        <= '0;
                        rdi_q       <= '0;
`endif
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    ready_q     <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_o          = ready_q;
    assign bus.out_valid_o      = out_valid_q;
    assign bus.rnd_ready_o      = (state_q == RND) && bus.rnd_valid_i;
    assign bus.state_o          = st_q;
    assign bus.perm_x_o         = st_q;
    assign bus.perm_rdi_o       = rdi_q;
    assign bus.perm_round_cnt_o = cnt_q;
    assign dbg_state            = state_q;

endmodule

// File: tb/tb_asconp_round_ctrl.sv
// Bench for asconp_round_ctrl: a behavioural masked-permutation stub closes the datapath loop,
// and unmasked results are scored against a software Ascon round model.
module tb_asconp_round_ctrl;
  localparam int D     = 2;
  localparam int RND_W = 5 * 64 * ((D - 1) * D / 2);
  localparam int SW    = 5 * D * 64;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RND  = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_UPD  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  int         n_checks;
  int         n_errors;
  int         rnd_mode;
  int         cyc;
  logic [319:0] exp_q[$];

  asconp_round_ctrl_if #(.D(D), .RND_W(RND_W)) bus ();

  asconp_round_ctrl #(.D(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // one unmasked Ascon round; round constant index is 12 - cnt
  function automatic logic [319:0] round_u(input logic [319:0] s, input logic [3:0] cnt);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [3:0]  t;
    logic [3:0]  hi;
    t  = 4'd12 - cnt;
    hi = 4'hf - t;
    x0 = s[0+:64]; x1 = s[64+:64]; x2 = s[128+:64]; x3 = s[192+:64]; x4 = s[256+:64];
    x2 = x2 ^ {56'd0, hi, t};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x4, x3, x2, x1, x0};
  endfunction

  function automatic logic [319:0] unmask(input logic [SW-1:0] sh);
    logic [319:0] u;
    for (int k = 0; k < 5; k++) u[k*64+:64] = sh[(2*k)*64+:64] ^ sh[(2*k+1)*64+:64];
    return u;
  endfunction

  function automatic logic [319:0] ref_perm(input logic [SW-1:0] init, input int eff);
    logic [319:0] u;
    u = unmask(init);
    for (int r = 0; r < eff; r++) u = round_u(u, 4'(eff - r));
    return u;
  endfunction

  // permutation stand-in: computes the round and re-shares it with the supplied randomness
  function automatic logic [SW-1:0] perm_stub(input logic [SW-1:0] x, input logic [3:0] cnt,
                                              input logic [RND_W-1:0] rdi);
    logic [319:0]   u;
    logic [SW-1:0]  o;
    u = round_u(unmask(x), cnt);
    for (int k = 0; k < 5; k++) begin
      o[(2*k)*64+:64]   = u[k*64+:64] ^ rdi[k*64+:64];
      o[(2*k+1)*64+:64] = rdi[k*64+:64];
    end
    return o;
  endfunction

  assign bus.perm_x_i = perm_stub(bus.perm_x_o, bus.perm_round_cnt_o, bus.perm_rdi_o);

  function automatic logic [SW-1:0] rand_vec();
    logic [SW-1:0] v;
    for (int i = 0; i < SW / 32; i++) v[i*32+:32] = $urandom;
    return v;
  endfunction

  function automatic logic [SW-1:0] zero_xor_vec();
    logic [SW-1:0] v;
    logic [63:0]   w;
    for (int k = 0; k < 5; k++) begin
      w = {$urandom, $urandom};
      v[(2*k)*64+:64]   = w;
      v[(2*k+1)*64+:64] = w;
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // PRNG driver: always valid (mode 0) or valid one cycle in four (mode 1)
  initial begin
    cyc = 0;
    bus.rnd_valid_i = 1'b0;
    bus.rnd_i = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.rnd_valid_i = (rnd_mode == 0) ? 1'b1 : (cyc % 4 == 0);
      for (int i = 0; i < RND_W / 32; i++) bus.rnd_i[i*32+:32] = $urandom;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(posedge clk);
    #1;
    while (!bus.ready_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ready_before_start", bus.ready_o, 1);
  endtask

  task automatic do_run(input logic [3:0] nr, input logic [SW-1:0] init, input int mode,
                        input int hold, input bit check_lat);
    int eff, lat, hs, rounds, bad;
    logic [RND_W-1:0] last_rdi;
    logic [SW-1:0]    x_calc, res;
    eff = (nr > 4'd12) ? 12 : int'(nr);
    rnd_mode = mode;
    wait_ready();
    bus.start_i = 1'b1;
    bus.nrounds_i = nr;
    bus.state_i = init;
    exp_q.push_back(ref_perm(init, eff));
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    lat = 0; hs = 0; rounds = 0; bad = 0; last_rdi = '0; x_calc = '0;
    forever begin
      @(negedge clk);
      if (bus.out_valid_o || lat > 400) break;
      case (dbg_state)
        S_RND: if (int'(bus.perm_round_cnt_o) != eff - rounds) bad++;
        S_CALC: begin
          if (int'(bus.perm_round_cnt_o) != eff - rounds) bad++;
          if (bus.perm_rdi_o !== last_rdi) bad++;
          x_calc = bus.perm_x_o;
        end
        S_UPD: begin
          if (int'(bus.perm_round_cnt_o) != eff - rounds) bad++;
          if (bus.perm_rdi_o !== last_rdi) bad++;
          if (bus.perm_x_o !== x_calc) bad++;
          rounds++;
        end
        default: bad++;
      endcase
      if (bus.rnd_ready_o !== ((dbg_state == S_RND) && bus.rnd_valid_i)) bad++;
      if (bus.ready_o) bad++;
      if (bus.rnd_valid_i && bus.rnd_ready_o) begin
        last_rdi = bus.rnd_i;
        hs++;
      end
      @(posedge clk);
      lat++;
    end
    check("out_valid", bus.out_valid_o, 1);
    if (check_lat) check("latency", lat, 3 * eff);
    check("rnd_handshakes", hs, eff);
    check("rounds_run", rounds, eff);
    check("round_seq_errs", bad, 0);
    if (eff == 0) check("passthrough", bus.state_o, init);
    res = bus.state_o;
    if (exp_q.size() > 0) check("result", unmask(res), exp_q.pop_front());
    else check("exp_q_underflow", 0, 1);
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      bus.start_i = 1'b1;
      bus.nrounds_i = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (bus.state_o !== res || !bus.out_valid_o || bus.ready_o || dbg_state != S_DONE) bad++;
    end
    if (hold > 0) check("hold_stable", bad, 0);
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b0;
    @(negedge clk);
    check("ready_after", bus.ready_o, 1);
    check("valid_after", bus.out_valid_o, 0);
`ifdef ASCONP_CTRL_ZEROIZE_EN
    check("zeroized_state", bus.state_o, 0);
    check("zeroized_rdi", bus.perm_rdi_o, 0);
`else
    check("retained_state", bus.state_o, res);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, bus.ready_o, 1);
    check({tag, "_valid"}, bus.out_valid_o, 0);
    check({tag, "_rnd_ready"}, bus.rnd_ready_o, 0);
    check({tag, "_state"}, bus.state_o, 0);
    check({tag, "_cnt"}, bus.perm_round_cnt_o, 0);
    check({tag, "_rdi"}, bus.perm_rdi_o, 0);
    check({tag, "_perm_x"}, bus.perm_x_o, 0);
    check({tag, "_fsm"}, dbg_state, S_IDLE);
  endtask

  task automatic reset_mid_run();
    int n;
    rnd_mode = 0;
    wait_ready();
    bus.start_i = 1'b1;
    bus.nrounds_i = 4'd12;
    bus.state_i = rand_vec();
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(dbg_state == S_CALC && bus.perm_round_cnt_o == 4'd8) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_round5", bus.perm_round_cnt_o, 8);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [SW-1:0] v0;
    n_checks = 0;
    n_errors = 0;
    rnd_mode = 0;
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.nrounds_i = '0;
    bus.state_i = '0;
    bus.out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    v0 = zero_xor_vec();
    do_run(4'd12, v0, 0, 0, 1'b1);
    do_run(4'd6, rand_vec(), 0, 0, 1'b1);
    do_run(4'd0, rand_vec(), 0, 0, 1'b1);
    do_run(4'd15, rand_vec(), 0, 0, 1'b1);
    do_run(4'd12, v0, 1, 0, 1'b0);
    do_run(4'd12, rand_vec(), 0, 10, 1'b1);
    do_run(4'd12, rand_vec(), 0, 0, 1'b1);
    do_run(4'd3, rand_vec(), 1, 2, 1'b0);
    reset_mid_run();
    do_run(4'd12, rand_vec(), 0, 0, 1'b1);
    check("exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // safety net so the run always ends
  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end
endmodule
